ps2_key_gen: RTL and testbench

Receives raw PS/2 keyboard clock/data lines, deframes scan-code bytes, and folds the E0/F0 prefixes into the 11-bit toggle-event word `ps2_key` that the game top levels decode for button state. It is the producing end of the `ps2_key` interface: it sits between the board-level PS/2 pins and the per-title keyboard decoder in `emu`, all in the `clk_sys` domain.

---
 rtl/ps2_key_gen_if.sv | 9 +
 rtl/ps2_key_gen.sv | 156 +++++++++++++++
 tb/tb_ps2_key_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_gen_if.sv
// Event-word bundle produced by ps2_key_gen and consumed by the per-title keyboard decoder.
interface ps2_key_gen_if;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (output ps2_key, frame_err, busy);
    modport slave  (input  ps2_key, frame_err, busy);
endinterface

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes scan-code bytes and folds
// E0/F0/E1 prefixes into the 11-bit toggle-event word.
module ps2_key_gen #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 50000
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    ps2_key_gen_if.master key_if
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_CHECK, S_DECODE} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
    logic          fall;

    assign fall = filt_prev_q & ~filt_q;

    // A level change is accepted only after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) filt_d = clk_s2_q;
            else                                 filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = tmo_q;
        ext_d       = ext_q;
        rel_d       = rel_q;
        skip_d      = skip_q;
        key_d       = key_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (fall) begin
                    if (!dat_s2_q) begin
                        state_d   = S_RX;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_RX: begin
                // A falling edge takes priority over an expiring timeout.
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[9:1]};
                    tmo_d   = '0;
                    if (bit_cnt_q == 4'd9) state_d = S_CHECK;
                    else                   bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (tmo_q != TW'(TIMEOUT)) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_CHECK: begin
                if (!shift_q[9] || !(^shift_q[8:0])) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (skip_q != 3'd0) begin
                    skip_d = skip_q - 1'b1;
                end else begin
                    case (shift_q[7:0])
                        8'hE1: skip_d = 3'd7;
                        8'hE0: ext_d  = 1'b1;
                        8'hF0: rel_d  = 1'b1;
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                        end
                        default: begin
                            key_d = {~key_q[10], ~rel_q, ext_q, shift_q[7:0]};
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= '0;
            key_q       <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk_i;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data_i;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            key_q       <= key_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign key_if.ps2_key   = key_q;
    assign key_if.frame_err = frame_err_q;
    assign key_if.busy      = busy_q;
endmodule

// File: tb/tb_ps2_key_gen.sv
// Scoreboard bench for ps2_key_gen: a byte-level keyboard model predicts events and
// frame errors; a free-running monitor pops and compares them as the DUT produces them.
module tb_ps2_key_gen;
    localparam int FILT_LEN = 4;
    localparam int TIMEOUT  = 2000;
    localparam int HALF     = 16;
    localparam int GAP      = 24;

    logic clk_sys = 1'b0;
    logic rst_n;
    logic ps2_clk;
    logic ps2_data;

    ps2_key_gen_if kif ();

    ps2_key_gen #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .key_if     (kif)
    );

    always #5 clk_sys = ~clk_sys;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] exp_q[$];
    bit          err_q[$];

    // Reference keyboard state
    bit       m_tog, m_ext, m_rel;
    int       m_skip;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic model_reset();
        m_tog = 0; m_ext = 0; m_rel = 0; m_skip = 0;
    endtask

    task automatic model_good_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
        end else begin
            m_tog = !m_tog;
            exp_q.push_back({m_tog, !m_rel, m_ext, b});
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    task automatic send_bit(input bit b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        if (bad_par || bad_stop) err_q.push_back(1'b1);
        else                     model_good_byte(b);
        send_raw(b, bad_par, bad_stop, 11);
        cyc(GAP);
    endtask

    // Monitor: every change of ps2_key and every frame_err pulse is matched against the scoreboard.
    initial begin
        logic [10:0] last_key;
        logic [10:0] e;
        bit          prev_err;
        last_key = '0;
        prev_err = 0;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                last_key = '0;
                prev_err = 0;
            end else begin
                if (kif.ps2_key !== last_key) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_event: got %h expected no event", kif.ps2_key);
                    end else begin
                        e = exp_q.pop_front();
                        if (kif.ps2_key !== e) begin
                            mismatched++;
                            $display("FAIL event: got %h expected %h", kif.ps2_key, e);
                        end
                    end
                    last_key = kif.ps2_key;
                end
                if (kif.frame_err) begin
                    compared++;
                    if (prev_err) begin
                        mismatched++;
                        $display("FAIL frame_err_width: got 2+ cycles expected 1");
                    end else if (err_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_frame_err: got 1 expected 0");
                    end else begin
                        void'(err_q.pop_front());
                    end
                end
                prev_err = kif.frame_err;
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        cyc(5);
        check("reset_key", kif.ps2_key, 11'h000);
        check("reset_err", kif.frame_err, 1'b0);
        check("reset_busy", kif.busy, 1'b0);
        rst_n = 1'b1;
        cyc(5);

        send_byte(8'h1C);
        check("key_1c", kif.ps2_key, 11'h61C);
        check("idle_busy", kif.busy, 1'b0);

        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'h75);

        send_byte(8'h29, 1'b1, 1'b0);
        send_byte(8'h29);

        // Truncated frame: start plus five data bits, then silence until the timeout.
        err_q.push_back(1'b1);
        send_raw(8'h16, 1'b0, 1'b0, 6);
        cyc(HALF);
        check("busy_partial", kif.busy, 1'b1);
        cyc(TIMEOUT + 50);
        check("busy_after_timeout", kif.busy, 1'b0);
        send_byte(8'h16);

        send_byte(8'h33, 1'b0, 1'b1);

        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'hAA);
        send_byte(8'h05);

        // Lone clock pulse with data high is a start error.
        err_q.push_back(1'b1);
        send_bit(1'b1);
        cyc(GAP);

        send_byte(8'hE0);
        send_raw(8'h6B, 1'b0, 1'b0, 4);
        cyc(3);
        rst_n = 1'b0;
        model_reset();
        cyc(5);
        check("midreset_key", kif.ps2_key, 11'h000);
        check("midreset_busy", kif.busy, 1'b0);
        rst_n = 1'b1;
        cyc(5);
        send_byte(8'h6B);
        check("key_6b", kif.ps2_key, 11'h66B);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 255));
            if (r == 0)      send_byte(b, 1'b1, 1'b0);
            else if (r == 1) send_byte(b, 1'b0, 1'b1);
            else if (r == 2) begin send_byte(8'hE0); send_byte(b); end
            else if (r == 3) begin send_byte(8'hF0); send_byte(b); end
            else             send_byte(b);
        end

        cyc(50);
        check("events_pending", exp_q.size(), 0);
        check("errors_pending", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
